// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM parameter controller: editor states and reset defaults.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EDIT_FRQ  = 2'd1,
        ST_EDIT_DUTY = 2'd2,
        ST_COMMIT    = 2'd3
    } pwm_state_e;

    localparam logic [31:0] FRQ_RESET  = 32'd200_000;
    localparam logic [19:0] DUTY_RESET = 20'd50;
    localparam logic [19:0] DUTY_MAX   = 20'd100;

endpackage

// File: rtl/key_debounce.sv
// Push-key conditioner: 2-flop synchronizer, counter debouncer, rising-edge event.
// Optional auto-repeat is built only with PWM_KEY_REPEAT_EN defined.
module key_debounce #(
    parameter int unsigned DB_CYCLES     = 1000,
    parameter bit          ALLOW_REPEAT  = 1'b0,
    parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic evt
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic           sync1;
    logic           sync2;
    logic           level;
    logic           level_d;
    logic [DBW-1:0] db_cnt;

    // The level flips only once DB_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            db_cnt  <= '0;
        end else begin
            sync1   <= key;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
                level  <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DBW'(1);
            end
        end
    end

`ifdef PWM_KEY_REPEAT_EN
    generate
        if (ALLOW_REPEAT) begin : g_repeat
            localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
            logic [RW-1:0] rpt_cnt;
            logic          held;
            logic          rpt_hit;

            assign held    = level & level_d;
            assign rpt_hit = held && (rpt_cnt == RW'(REPEAT_CYCLES - 1));

            always_ff @(posedge clk) begin
                if (rst) begin
                    rpt_cnt <= '0;
                end else if (!held || rpt_hit) begin
                    rpt_cnt <= '0;
                end else begin
                    rpt_cnt <= rpt_cnt + RW'(1);
                end
            end

            assign evt = (level & ~level_d) | rpt_hit;
        end else begin : g_single
            assign evt = level & ~level_d;
        end
    endgenerate
`else
    assign evt = level & ~level_d;
`endif

endmodule

// File: rtl/pwm_param_ctrl.sv
// Key-driven editor for PWM frequency/duty with a commit strobe to the PWM generator.
// Define PWM_KEY_REPEAT_EN to enable auto-repeat on held up/down keys.
module pwm_param_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 1000,
    parameter int unsigned FRQ_MIN       = 1000,
    parameter int unsigned FRQ_MAX       = 10_000_000,
    parameter int unsigned FRQ_STEP      = 1000,
    parameter int unsigned DUTY_STEP     = 5,
    parameter int unsigned OK_HOLD       = 4,
    parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_sel,
    input  logic        key_ok,
    output logic [31:0] frq_data,
    output logic [19:0] duty_data,
    output logic        sw_ok,
    output logic [1:0]  edit_mode
);

    localparam logic [1:0] S_IDLE      = 2'(ST_IDLE);
    localparam logic [1:0] S_EDIT_FRQ  = 2'(ST_EDIT_FRQ);
    localparam logic [1:0] S_EDIT_DUTY = 2'(ST_EDIT_DUTY);
    localparam logic [1:0] S_COMMIT    = 2'(ST_COMMIT);
    localparam int HW = $clog2(OK_HOLD);

    logic          up_ev, dn_ev, sel_ev, ok_ev;
    logic [1:0]    state;
    logic [HW-1:0] hold_cnt;
    logic [31:0]   frq_work;
    logic [19:0]   duty_work;
    logic [32:0]   frq_inc;
    logic [20:0]   duty_inc;
    logic [31:0]   frq_up, frq_dn;
    logic [19:0]   duty_up, duty_dn;
    logic          step_up, step_dn;

    key_debounce #(.DB_CYCLES(DB_CYCLES), .ALLOW_REPEAT(1'b1), .REPEAT_CYCLES(REPEAT_CYCLES))
        u_key_up   (.clk(clk), .rst(rst), .key(key_up),   .evt(up_ev));
    key_debounce #(.DB_CYCLES(DB_CYCLES), .ALLOW_REPEAT(1'b1), .REPEAT_CYCLES(REPEAT_CYCLES))
        u_key_down (.clk(clk), .rst(rst), .key(key_down), .evt(dn_ev));
    key_debounce #(.DB_CYCLES(DB_CYCLES), .ALLOW_REPEAT(1'b0), .REPEAT_CYCLES(REPEAT_CYCLES))
        u_key_sel  (.clk(clk), .rst(rst), .key(key_sel),  .evt(sel_ev));
    key_debounce #(.DB_CYCLES(DB_CYCLES), .ALLOW_REPEAT(1'b0), .REPEAT_CYCLES(REPEAT_CYCLES))
        u_key_ok   (.clk(clk), .rst(rst), .key(key_ok),   .evt(ok_ev));

    assign step_up = up_ev & ~dn_ev;
    assign step_dn = dn_ev & ~up_ev;

    // Widened intermediates keep the saturation compares free of wrap-around.
    always_comb begin
        frq_inc  = {1'b0, frq_work} + 33'(FRQ_STEP);
        duty_inc = {1'b0, duty_work} + 21'(DUTY_STEP);
        frq_up   = (frq_inc > 33'(FRQ_MAX)) ? 32'(FRQ_MAX) : frq_inc[31:0];
        frq_dn   = ({1'b0, frq_work} < (33'(FRQ_MIN) + 33'(FRQ_STEP)))
                   ? 32'(FRQ_MIN) : (frq_work - 32'(FRQ_STEP));
        duty_up  = (duty_inc > {1'b0, DUTY_MAX}) ? DUTY_MAX : duty_inc[19:0];
        duty_dn  = ({1'b0, duty_work} < 21'(DUTY_STEP))
                   ? 20'd0 : (duty_work - 20'(DUTY_STEP));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            sw_ok     <= 1'b0;
            frq_work  <= FRQ_RESET;
            frq_data  <= FRQ_RESET;
            duty_work <= DUTY_RESET;
            duty_data <= DUTY_RESET;
        end else begin
            sw_ok <= (state == S_COMMIT);
            case (state)
                S_IDLE: begin
                    if (sel_ev) state <= S_EDIT_FRQ;
                end
                S_EDIT_FRQ, S_EDIT_DUTY: begin
                    // ok beats sel; the commit captures the value before any same-cycle step.
                    if (ok_ev) begin
                        state     <= S_COMMIT;
                        hold_cnt  <= '0;
                        frq_data  <= frq_work;
                        duty_data <= duty_work;
                    end else if (sel_ev) begin
                        state <= (state == S_EDIT_FRQ) ? S_EDIT_DUTY : S_EDIT_FRQ;
                    end
                    if (state == S_EDIT_FRQ) begin
                        if (step_up)      frq_work <= frq_up;
                        else if (step_dn) frq_work <= frq_dn;
                    end else begin
                        if (step_up)      duty_work <= duty_up;
                        else if (step_dn) duty_work <= duty_dn;
                    end
                end
                S_COMMIT: begin
                    if (hold_cnt == HW'(OK_HOLD - 1)) begin
                        state    <= S_IDLE;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign edit_mode = state;

endmodule

// File: doc/pwm_param_ctrl.md
PWM_PARAM_CTRL -- requirements
Module: pwm_param_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000, meaning the number of consecutive equal key samples needed to accept a level change.
REQ-002 SHALL have parameter FRQ_MIN, default 1000, meaning the lowest frequency value in Hz.
REQ-003 SHALL have parameter FRQ_MAX, default 10_000_000, meaning the highest frequency value in Hz.
REQ-004 SHALL have parameter FRQ_STEP, default 1000, meaning the frequency change in Hz per key event.
REQ-005 SHALL have parameter DUTY_STEP, default 5, meaning the duty change in percent per key event.
REQ-006 SHALL have parameter OK_HOLD, default 4, meaning the sw_ok high width in cycles (minimum 3).
REQ-007 SHALL have parameter REPEAT_CYCLES, default 5_000_000, meaning the auto-repeat period in cycles.
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have ports key_up, key_down, key_sel and key_ok, each input, 1 bit: raw asynchronous push-keys, high = pressed.
REQ-011 SHALL have port frq_data, output, 32 bits: committed frequency in Hz.
REQ-012 SHALL have port duty_data, output, 20 bits: committed duty in percent, range 0..100.
REQ-013 SHALL have port sw_ok, output, 1 bit: commit strobe for the downstream PWM generator.
REQ-014 SHALL have port edit_mode, output, 2 bits: 0 = IDLE, 1 = FRQ, 2 = DUTY, 3 = COMMIT, for display.

Function
REQ-015 SHALL pass each key through a 2-flop synchronizer and then a debouncer; the debounced level changes only after DB_CYCLES consecutive equal samples.
REQ-016 SHALL generate a one-cycle event on each rising edge of a debounced level; falling edges generate no event.
REQ-017 SHALL implement FSM states IDLE, EDIT_FRQ, EDIT_DUTY and COMMIT.
REQ-018 SHALL make the following FSM transitions on a sel event: IDLE->EDIT_FRQ, EDIT_FRQ->EDIT_DUTY, EDIT_DUTY->EDIT_FRQ.
REQ-019 SHALL go from EDIT_FRQ or EDIT_DUTY to COMMIT on an ok event; an ok event and a sel event in the same cycle -> ok wins.
REQ-020 SHALL remain in COMMIT exactly OK_HOLD cycles and then enter IDLE; all key events are ignored in IDLE (except sel) and throughout COMMIT.
REQ-021 SHALL apply an up/down event in EDIT_FRQ to frq_work (+/-FRQ_STEP) and in EDIT_DUTY to duty_work (+/-DUTY_STEP), in the cycle after the event.
REQ-022 SHALL treat up and down events in the same cycle as no change.
REQ-023 SHALL saturate values: frq_work is clamped to [FRQ_MIN, FRQ_MAX] and duty_work to [0, 100]; comparisons use 33-bit / 21-bit intermediates so no wrap-around can occur.
REQ-024 SHALL, on the COMMIT entry edge, register frq_data <= frq_work and duty_data <= duty_work; outputs SHALL be stable at all other times.
REQ-025 SHALL drive sw_ok registered, high for exactly the OK_HOLD COMMIT cycles, rising one cycle after frq_data/duty_data update.
REQ-026 SHALL ensure a second commit produces a fresh sw_ok rising edge, since it is separated by at least one IDLE cycle.

Reset
REQ-027 SHALL, with rst high at posedge clk, set: state IDLE, edit_mode 0, sw_ok 0, frq_data and frq_work 200000, duty_data and duty_work 50, debounced levels released, all counters 0.
REQ-028 SHALL, if rst is asserted mid-COMMIT, drop sw_ok to 0 at that same edge with no further strobe.

Configuration
REQ-029 SHALL, with macro PWM_KEY_REPEAT_EN defined, make a key (up or down only) held debounced-pressed emit an additional event every REPEAT_CYCLES after the first event.
REQ-030 SHALL, without PWM_KEY_REPEAT_EN, emit exactly one event per press; REPEAT_CYCLES is then unused and no repeat counter is synthesized.

Structure
REQ-031 SHALL place the FSM state enum, the reset defaults (200000, 50) and DUTY_MAX = 100 in shared package pwm_ctrl_pkg.
REQ-032 SHALL implement synchronizer, debounce and edge-event logic in sub-module key_debounce, instantiated four times.

Verification
REQ-033 SHALL cover, with DB_CYCLES = 4, a 2-cycle glitch on key_up in EDIT_FRQ -> no event, frq_work unchanged at 200000.
REQ-034 SHALL cover sel, up x3, ok -> frq_data = 203000, duty_data = 50, sw_ok high 4 cycles, edit_mode returns to 0.
REQ-035 SHALL cover sel, sel, up x12, ok -> duty_data = 100 (saturated); down x21 then ok -> duty_data = 0.
REQ-036 SHALL cover frq_work = 10_000_000 with an up event -> it stays 10_000_000; FRQ_MIN = 1000 with a down event -> it stays 1000.
REQ-037 SHALL cover up and down events in the same cycle -> no change; ok and sel in the same cycle -> COMMIT.
REQ-038 SHALL cover rst asserted on the 2nd COMMIT cycle -> sw_ok 0 at that edge, frq_data = 200000, state IDLE.
